// File: rtl/cmd_parser.sv
// cmd_parser: UART command decoder for the LED controller.
// A single-letter command selects the display mode, loads a 9-byte pattern
// into the staging register, copies staging to the user intensities, or
// writes staging into pattern RAM at an address given by the next byte.
// Optional feature macro: CMD_PARSER_TIMEOUT_EN. When it is defined, a
// command left half-finished for TIMEOUT_CYCLES idle cycles is aborted.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a command letter
// LOAD  | collecting the 9 pattern bytes into the load register
// ADDR  | waiting for the pattern RAM address byte of a "w" command
module cmd_parser #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic [1:0]  mode,
  output logic [71:0] user_int,
  output logic        pat_we,
  output logic [7:0]  pat_addr,
  output logic [71:0] pat_data,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LOAD, ADDR} state_t;

  localparam logic [7:0] CH_A = 8'h61;
  localparam logic [7:0] CH_R = 8'h72;
  localparam logic [7:0] CH_S = 8'h73;
  localparam logic [7:0] CH_I = 8'h69;
  localparam logic [7:0] CH_P = 8'h70;
  localparam logic [7:0] CH_U = 8'h75;
  localparam logic [7:0] CH_W = 8'h77;

  state_t      state, state_nxt;
  logic [1:0]  mode_nxt;
  logic [71:0] user_nxt;
  logic [71:0] staging, staging_nxt;
  logic [71:0] load_reg, load_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [7:0]  addr_nxt;
  logic        we_nxt;
  logic        err_nxt;
  logic [71:0] load_shift;

`ifdef CMD_PARSER_TIMEOUT_EN
  logic [15:0] tmo_cnt, tmo_nxt;
  localparam logic [15:0] TMO_LAST = TIMEOUT_CYCLES - 16'd1;
`endif

  assign load_shift = {load_reg[63:0], rx_byte};
  assign pat_data   = staging;

  // State and datapath registers; reset wins over any byte in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode     <= 2'd0;
      user_int <= '0;
      staging  <= '0;
      load_reg <= '0;
      cnt      <= '0;
      pat_addr <= '0;
      pat_we   <= 1'b0;
      err      <= 1'b0;
`ifdef CMD_PARSER_TIMEOUT_EN
      tmo_cnt  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      mode     <= mode_nxt;
      user_int <= user_nxt;
      staging  <= staging_nxt;
      load_reg <= load_nxt;
      cnt      <= cnt_nxt;
      pat_addr <= addr_nxt;
      pat_we   <= we_nxt;
      err      <= err_nxt;
`ifdef CMD_PARSER_TIMEOUT_EN
      tmo_cnt  <= tmo_nxt;
`endif
    end
  end

  // Next-state decode: command letters in IDLE, data bytes in LOAD/ADDR.
  always_comb begin
    state_nxt   = state;
    mode_nxt    = mode;
    user_nxt    = user_int;
    staging_nxt = staging;
    load_nxt    = load_reg;
    cnt_nxt     = cnt;
    addr_nxt    = pat_addr;
    we_nxt      = 1'b0;
    err_nxt     = 1'b0;
`ifdef CMD_PARSER_TIMEOUT_EN
    tmo_nxt     = tmo_cnt;
`endif

    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_byte)
            CH_A: mode_nxt = 2'd0;
            CH_R: mode_nxt = 2'd1;
            CH_S: mode_nxt = 2'd2;
            CH_I: mode_nxt = 2'd3;
            CH_P: begin
              load_nxt  = '0;
              cnt_nxt   = '0;
              state_nxt = LOAD;
            end
            CH_U: user_nxt = staging;
            CH_W: state_nxt = ADDR;
            default: err_nxt = 1'b1;
          endcase
        end
      end
      LOAD: begin
        if (rx_valid) begin
          load_nxt = load_shift;
          cnt_nxt  = cnt + 4'd1;
          // Ninth byte: the shifted value is complete, publish it.
          if (cnt == 4'd8) begin
            staging_nxt = load_shift;
            state_nxt   = IDLE;
          end
        end
      end
      ADDR: begin
        if (rx_valid) begin
          addr_nxt  = rx_byte;
          we_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

`ifdef CMD_PARSER_TIMEOUT_EN
    // A byte arriving on the expiry cycle is processed above and the
    // timeout is dropped, since rx_valid clears the counter first.
    if (state != IDLE) begin
      if (rx_valid) begin
        tmo_nxt = '0;
      end else if (tmo_cnt == TMO_LAST) begin
        state_nxt = IDLE;
        load_nxt  = '0;
        err_nxt   = 1'b1;
        tmo_nxt   = '0;
      end else begin
        tmo_nxt = tmo_cnt + 16'd1;
      end
    end
    if (state_nxt == IDLE) tmo_nxt = '0;
`endif
  end

endmodule
